sdram_cmd_initiator: RTL and testbench

//  Host-side initiator for the team's single-beat SDRAM command interface: turns one host read/write

---
 rtl/sdram_cmd_initiator_if.sv | 36 +++
 rtl/sdram_cmd_initiator.sv | 227 ++++++++++++++++++++++
 tb/tb_sdram_cmd_initiator.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_initiator_if.sv
// Host handshake and SDRAM command-bus signal bundle for sdram_cmd_initiator.
// master = host/memory environment side, slave = initiator side.
interface sdram_cmd_initiator_if #(
   parameter int unsigned DATA  = 32,
   parameter int unsigned ROW_W = 14,
   parameter int unsigned COL_W = 9
);
   localparam int unsigned AW = ROW_W + COL_W + 2;

   logic            req;
   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [DATA-1:0] req_wdata;
   logic            req_ready;
   logic            rd_valid;
   logic [DATA-1:0] rd_data;

   logic            cs;
   logic            ras;
   logic            cas;
   logic            we;
   logic [1:0]      bank;
   logic [ROW_W-1:0] addr;
   logic [DATA-1:0] wdata;
   logic [DATA-1:0] rdata;

   modport master (
      output req, req_write, req_addr, req_wdata, rdata,
      input  req_ready, rd_valid, rd_data, cs, ras, cas, we, bank, addr, wdata
   );

   modport slave (
      input  req, req_write, req_addr, req_wdata, rdata,
      output req_ready, rd_valid, rd_data, cs, ras, cas, we, bank, addr, wdata
   );
endinterface

// File: rtl/sdram_cmd_initiator.sv
// Single-request SDRAM command initiator: ACT -> (TRCD) -> RD/WR CAS -> wait, with NOP-counter mirror.
// Define SDRAM_ROW_HIT_EN to skip ACT/TRCD when the requested row is already open.
module sdram_cmd_initiator #(
   parameter int unsigned DATA    = 32,
   parameter int unsigned ROW_W   = 14,
   parameter int unsigned COL_W   = 9,
   parameter int unsigned TRCD    = 1,
   parameter int unsigned CAS_LAT = 1
) (
   input  logic                     in_CLK,
   input  logic                     in_RST_N,
   input  logic                     in_req,
   input  logic                     in_req_write,
   input  logic [ROW_W+COL_W+1:0]   in_req_addr,
   input  logic [DATA-1:0]          in_req_wdata,
   output logic                     out_req_ready,
   output logic                     out_rd_valid,
   output logic [DATA-1:0]          out_rd_data,
   output logic                     out_CS,
   output logic                     out_RAS,
   output logic                     out_CAS,
   output logic                     out_write_en,
   output logic [1:0]               out_bank_select,
   output logic [ROW_W-1:0]         out_sdram_addr,
   output logic [DATA-1:0]          out_sdram_write_data,
   input  logic [DATA-1:0]          in_sdram_read_data
);
   localparam int unsigned AW = ROW_W + COL_W + 2;

   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_RD    = 4'b0101;
   localparam logic [3:0] CMD_WR    = 4'b0100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACT,
      S_TRCD_WAIT,
      S_CAS,
      S_WR_WAIT,
      S_RD_WAIT
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cmd;
   logic [1:0]        r_bank;
   logic [ROW_W-1:0]  r_addr;
   logic [DATA-1:0]   r_wdata;
   logic              r_ready;
   logic              r_rd_valid;
   logic [DATA-1:0]   r_rd_data;
   logic [1:0]        r_mirror;
   logic [2:0]        r_cnt;
   logic              r_req_write;
   logic [1:0]        r_req_bank;
   logic [COL_W-1:0]  r_req_col;
   logic [DATA-1:0]   r_req_wdata;
`ifdef SDRAM_ROW_HIT_EN
   logic [ROW_W-1:0]  r_open_row;
   logic              r_row_valid;
`endif

   logic [1:0]        w_in_bank;
   logic [ROW_W-1:0]  w_in_row;
   logic [COL_W-1:0]  w_in_col;
   logic              w_row_hit;
   logic              w_go_cas;
   logic              w_sel_write;
   logic [1:0]        w_sel_bank;
   logic [COL_W-1:0]  w_sel_col;
   logic [DATA-1:0]   w_sel_wdata;
   logic [1:0]        w_mirror_nxt;

   assign w_in_bank = in_req_addr[AW-1 -: 2];
   assign w_in_row  = in_req_addr[COL_W +: ROW_W];
   assign w_in_col  = in_req_addr[COL_W-1:0];

`ifdef SDRAM_ROW_HIT_EN
   assign w_row_hit = r_row_valid && (w_in_row == r_open_row);
`else
   assign w_row_hit = 1'b0;
`endif

   // CAS operands come straight from the host on a row hit, otherwise from the latched request
   always_comb begin
      w_sel_write = r_req_write;
      w_sel_bank  = r_req_bank;
      w_sel_col   = r_req_col;
      w_sel_wdata = r_req_wdata;
      if (r_state == S_IDLE) begin
         w_sel_write = in_req_write;
         w_sel_bank  = w_in_bank;
         w_sel_col   = w_in_col;
         w_sel_wdata = in_req_wdata;
      end
   end

   always_comb begin
      w_go_cas = 1'b0;
      case (r_state)
         S_IDLE:      w_go_cas = in_req && w_row_hit;
         S_ACT:       w_go_cas = (TRCD == 0);
         S_TRCD_WAIT: w_go_cas = (r_cnt == '0);
         default:     w_go_cas = 1'b0;
      endcase
   end

   // Memory NOP counter as it will be after the command currently on the bus
   always_comb begin
      w_mirror_nxt = r_mirror;
      if (!r_cmd[3]) begin
         if (r_mirror == 2'd3)
            w_mirror_nxt = '0;
         else if (r_cmd == CMD_NOP)
            w_mirror_nxt = r_mirror + 2'd1;
      end
   end

   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         r_state     <= S_IDLE;
         r_cmd       <= CMD_DESEL;
         r_bank      <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ready     <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_mirror    <= '0;
         r_cnt       <= '0;
         r_req_write <= 1'b0;
         r_req_bank  <= '0;
         r_req_col   <= '0;
         r_req_wdata <= '0;
`ifdef SDRAM_ROW_HIT_EN
         r_open_row  <= '0;
         r_row_valid <= 1'b0;
`endif
      end else begin
         r_mirror   <= w_mirror_nxt;
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_req) begin
                  r_req_write <= in_req_write;
                  r_req_bank  <= w_in_bank;
                  r_req_col   <= w_in_col;
                  r_req_wdata <= in_req_wdata;
                  r_ready     <= 1'b0;
                  if (!w_row_hit) begin
                     r_state <= S_ACT;
                     r_cmd   <= CMD_ACT;
                     r_bank  <= w_in_bank;
                     r_addr  <= w_in_row;
`ifdef SDRAM_ROW_HIT_EN
                     r_open_row  <= w_in_row;
                     r_row_valid <= 1'b1;
`endif
                  end
               end
            end
            S_ACT: begin
               if (TRCD != 0) begin
                  r_state <= S_TRCD_WAIT;
                  r_cmd   <= CMD_DESEL;
                  r_cnt   <= 3'(TRCD - 1);
               end
            end
            S_TRCD_WAIT: begin
               if (r_cnt != '0)
                  r_cnt <= r_cnt - 3'd1;
            end
            S_CAS: begin
               if (r_req_write) begin
                  r_state <= S_WR_WAIT;
                  r_cmd   <= CMD_NOP;
               end else begin
                  r_state <= S_RD_WAIT;
                  r_cmd   <= CMD_DESEL;
                  r_cnt   <= 3'(CAS_LAT - 1);
               end
            end
            S_WR_WAIT: begin
               // the NOP issued while the counter reads 2 is the one that commits the write
               if (r_mirror == 2'd2) begin
                  r_state <= S_IDLE;
                  r_cmd   <= CMD_DESEL;
                  r_ready <= 1'b1;
               end
            end
            S_RD_WAIT: begin
               if (r_cnt == '0) begin
                  r_state    <= S_IDLE;
                  r_rd_data  <= in_sdram_read_data;
                  r_rd_valid <= 1'b1;
                  r_ready    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cmd   <= CMD_DESEL;
               r_ready <= 1'b1;
            end
         endcase
         // later assignments win: ACT, TRCD expiry and row hits all converge here
         if (w_go_cas) begin
            r_state <= S_CAS;
            r_cmd   <= w_sel_write ? CMD_WR : CMD_RD;
            r_bank  <= w_sel_bank;
            r_addr  <= {{(ROW_W-COL_W){1'b0}}, w_sel_col};
            if (w_sel_write)
               r_wdata <= w_sel_wdata;
         end
      end
   end

   assign {out_CS, out_RAS, out_CAS, out_write_en} = r_cmd;
   assign out_bank_select      = r_bank;
   assign out_sdram_addr       = r_addr;
   assign out_sdram_write_data = r_wdata;
   assign out_req_ready        = r_ready;
   assign out_rd_valid         = r_rd_valid;
   assign out_rd_data          = r_rd_data;
endmodule

// File: tb/tb_sdram_cmd_initiator.sv
// Directed bench for sdram_cmd_initiator: host driver, behavioural SDRAM with NOP counter, scoreboards.
`timescale 1ns/1ps
module tb_sdram_cmd_initiator;
   localparam int unsigned DATA    = 32;
   localparam int unsigned ROW_W   = 14;
   localparam int unsigned COL_W   = 9;
   localparam int unsigned TRCD    = 1;
   localparam int unsigned CAS_LAT = 1;

   localparam logic [3:0] C_DESEL = 4'b1111;
   localparam logic [3:0] C_NOP   = 4'b0111;
   localparam logic [3:0] C_ACT   = 4'b0011;
   localparam logic [3:0] C_RD    = 4'b0101;
   localparam logic [3:0] C_WR    = 4'b0100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_cmd_initiator_if #(.DATA(DATA), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

   sdram_cmd_initiator #(
      .DATA(DATA), .ROW_W(ROW_W), .COL_W(COL_W), .TRCD(TRCD), .CAS_LAT(CAS_LAT)
   ) dut (
      .in_CLK               (clk),
      .in_RST_N             (rst_n),
      .in_req               (bus.req),
      .in_req_write         (bus.req_write),
      .in_req_addr          (bus.req_addr),
      .in_req_wdata         (bus.req_wdata),
      .out_req_ready        (bus.req_ready),
      .out_rd_valid         (bus.rd_valid),
      .out_rd_data          (bus.rd_data),
      .out_CS               (bus.cs),
      .out_RAS              (bus.ras),
      .out_CAS              (bus.cas),
      .out_write_en         (bus.we),
      .out_bank_select      (bus.bank),
      .out_sdram_addr       (bus.addr),
      .out_sdram_write_data (bus.wdata),
      .in_sdram_read_data   (bus.rdata)
   );

   logic [3:0] w_cmd;
   assign w_cmd = {bus.cs, bus.ras, bus.cas, bus.we};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural SDRAM ----------------
   logic [1:0]  mem_ctr;
   logic [13:0] mem_row;
   logic        mem_wpend;
   logic [24:0] mem_wkey;
   logic        mem_commit;
   logic        mem_cwpend;
   logic [24:0] mem_ckey;
   logic [31:0] mem_cdata;
   logic [24:0] mem_key [64];
   logic [31:0] mem_val [64];
   int          mem_n = 0;

   function automatic int mem_slot(input logic [24:0] k);
      for (int i = 0; i < mem_n; i++)
         if (mem_key[i] == k) return i;
      return mem_n;
   endfunction

   function automatic logic [31:0] mem_lookup(input logic [24:0] k);
      for (int i = 0; i < mem_n; i++)
         if (mem_key[i] == k) return mem_val[i];
      return '0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ctr    <= '0;
         mem_wpend  <= 1'b0;
         mem_commit <= 1'b0;
      end else begin
         mem_commit <= 1'b0;
         if (!w_cmd[3]) begin
            if (mem_ctr == 2'd3) mem_ctr <= '0;
            else if (w_cmd == C_NOP) mem_ctr <= mem_ctr + 2'd1;
         end
         case (w_cmd)
            C_ACT: mem_row <= bus.addr;
            C_WR: begin
               mem_wkey  <= {bus.bank, mem_row, bus.addr[COL_W-1:0]};
               mem_wpend <= 1'b1;
            end
            C_RD: bus.rdata <= mem_lookup({bus.bank, mem_row, bus.addr[COL_W-1:0]});
            C_NOP: if (mem_ctr == 2'd2) begin
               mem_commit <= 1'b1;
               mem_cwpend <= mem_wpend;
               mem_ckey   <= mem_wkey;
               mem_cdata  <= bus.wdata;
               mem_wpend  <= 1'b0;
               mem_key[mem_slot(mem_wkey)] <= mem_wkey;
               mem_val[mem_slot(mem_wkey)] <= bus.wdata;
               if (mem_slot(mem_wkey) == mem_n) mem_n <= mem_n + 1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- scoreboards ----------------
   logic [56:0] wq [$];
   logic [31:0] rq [$];
   logic [56:0] exp_w;
   logic [31:0] exp_r;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_commit) begin
            chk("wr preceded by WR cas", mem_cwpend, 1);
            chk("wr expected", wq.size() > 0, 1);
            if (wq.size() > 0) begin
               exp_w = wq.pop_front();
               chk("wr addr", mem_ckey, exp_w[56:32]);
               chk("wr data", mem_cdata, exp_w[31:0]);
            end
         end
         if (bus.rd_valid === 1'b1) begin
            chk("rd expected", rq.size() > 0, 1);
            if (rq.size() > 0) begin
               exp_r = rq.pop_front();
               chk("rd data", bus.rd_data, exp_r);
            end
         end
         if (w_cmd == C_RD || w_cmd == C_WR)
            chk("cas addr upper bits", bus.addr[ROW_W-1:COL_W], 0);
      end
   end

   // ---------------- host driver and protocol model ----------------
   logic [1:0]  m_mirror = '0;
   logic [13:0] m_row = '0;
   logic        m_row_valid = 1'b0;
   logic [31:0] ref_mem [logic [24:0]];

   function automatic logic [1:0] mnext(input logic [1:0] m, input logic [3:0] c);
      if (c[3]) return m;
      if (m == 2'd3) return 2'd0;
      if (c == C_NOP) return m + 2'd1;
      return m;
   endfunction

   task automatic do_req(input string tag, input logic wr, input logic [1:0] bk,
                         input logic [13:0] row, input logic [8:0] col,
                         input logic [31:0] wd, input int unsigned abort_at);
      logic [3:0]  seq [$];
      logic        hit;
      logic        last;
      int unsigned guard;
      logic [24:0] key;
      key = {bk, row, col};
      hit = 1'b0;
`ifdef SDRAM_ROW_HIT_EN
      hit = m_row_valid && (m_row == row);
`endif
      if (!hit) begin
         seq.push_back(C_ACT);
         m_mirror = mnext(m_mirror, C_ACT);
         for (int unsigned i = 0; i < TRCD; i++) seq.push_back(C_DESEL);
         m_row = row;
         m_row_valid = 1'b1;
      end
      seq.push_back(wr ? C_WR : C_RD);
      m_mirror = mnext(m_mirror, wr ? C_WR : C_RD);
      if (wr) begin
         do begin
            last = (m_mirror == 2'd2);
            seq.push_back(C_NOP);
            m_mirror = mnext(m_mirror, C_NOP);
         end while (!last);
      end else begin
         for (int unsigned i = 0; i < CAS_LAT; i++) seq.push_back(C_DESEL);
      end
      if (abort_at == 0) begin
         if (wr) begin
            wq.push_back({key, wd});
            ref_mem[key] = wd;
         end else begin
            rq.push_back(ref_mem.exists(key) ? ref_mem[key] : 32'h0);
         end
      end

      bus.req = 1'b1;
      bus.req_write = wr;
      bus.req_addr = key;
      bus.req_wdata = wd;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " ready seen"}, guard < 50, 1);
      if (guard >= 50) begin
         bus.req = 1'b0;
         return;
      end
      for (int i = 0; i < int'(seq.size()); i++) begin
         @(negedge clk);
         bus.req = 1'b0;
         chk($sformatf("%s cmd[%0d]", tag, i), w_cmd, seq[i]);
         if (i == 0) chk({tag, " busy"}, bus.req_ready, 0);
         if (abort_at != 0 && i + 1 == int'(abort_at)) begin
            #2 rst_n = 1'b0;
            #1;
            chk({tag, " abort cmd"}, w_cmd, C_DESEL);
            chk({tag, " abort ready"}, bus.req_ready, 1);
            chk({tag, " abort rd_valid"}, bus.rd_valid, 0);
            chk({tag, " abort addr"}, bus.addr, 0);
            m_mirror = '0;
            m_row_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end
      @(negedge clk);
      chk({tag, " end cmd"}, w_cmd, C_DESEL);
      chk({tag, " end ready"}, bus.req_ready, 1);
      chk({tag, " rd_valid"}, bus.rd_valid, !wr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      bus.req = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset cmd", w_cmd, C_DESEL);
      chk("reset ready", bus.req_ready, 1);
      chk("reset rd_valid", bus.rd_valid, 0);
      chk("reset rd_data", bus.rd_data, 0);
      chk("reset bank", bus.bank, 0);
      chk("reset addr", bus.addr, 0);
      chk("reset wdata", bus.wdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_req("t1 abort wr", 1'b1, 2'd1, 14'h0123, 9'h045, 32'hCAFEF00D, 5);
      do_req("t2 wr", 1'b1, 2'd1, 14'h0123, 9'h045, 32'hDEADBEEF, 0);
      do_req("t4 wr mirror3", 1'b1, 2'd0, 14'h0123, 9'h010, 32'h00000001, 0);
      do_req("t3 rd", 1'b0, 2'd1, 14'h0123, 9'h045, '0, 0);
      do_req("t4 rd", 1'b0, 2'd0, 14'h0123, 9'h010, '0, 0);

      for (int b = 0; b < 4; b++)
         do_req($sformatf("t5 wr b%0d", b), 1'b1, 2'(b), 14'(14'h0100 + b), 9'h1FF,
                32'hA5000000 | 32'(b * 17), 0);
      for (int b = 0; b < 4; b++)
         do_req($sformatf("t5 rd b%0d", b), 1'b0, 2'(b), 14'(14'h0100 + b), 9'h1FF, '0, 0);

      do_req("t6 wr b0", 1'b1, 2'd0, 14'h0123, 9'h033, 32'h11112222, 0);
      do_req("t6 wr b2", 1'b1, 2'd2, 14'h0123, 9'h033, 32'h33334444, 0);
      do_req("t6 rd b0", 1'b0, 2'd0, 14'h0123, 9'h033, '0, 0);
      do_req("t6 rd b2", 1'b0, 2'd2, 14'h0123, 9'h033, '0, 0);

      for (int n = 0; n < 12; n++) begin
         d = $urandom;
         do_req($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) != 0) ? 14'h0123 : 14'h0200,
                ($urandom_range(0, 1) != 0) ? 9'h1FF : 9'h045, d, 0);
         if ($urandom_range(0, 2) == 0) repeat (2) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("writes drained", wq.size(), 0);
      chk("reads drained", rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
